// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Exports: state_t, PCSrc encodings and the zero-register index.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_J   = 2'd2;
    localparam logic [1:0] PCSRC_JR  = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter for the stall/flush performance counters.
// Ports: clk, reset (async active-low), inc, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: load-use interlock, control flushes, memory wait.
// Outputs enables/flushes (Mealy), sticky mem_timeout, stall/flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [1:0]       id_PCSrc,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_dest,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             hazard,
    output logic             pipe_en,
    output logic             idex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state, state_d;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic              load_use;
    logic              freeze;
    logic              stall_inc;

    assign load_use = ex_MemRead && (ex_dest != REG_ZERO) &&
                      ((ex_dest == id_rs) || (ex_dest == id_rt));

    assign freeze = ((state == MEM_WAIT) && !mem_ready) ||
                    ((state == RUN) && mem_req && !mem_ready) ||
                    (state == ERROR);

    always_comb begin
        state_d = state;
        wait_d  = wait_cnt;
        unique case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            wait_cnt    <= wait_d;
            mem_timeout <= mem_timeout || (state_d == ERROR);
        end
    end

    // Conditions overlap, so first match wins (priority order matters).
    // While reset is held the outputs are forced to their idle values.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        pipe_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        hazard     = 1'b0;
        if (reset) begin
            priority case (1'b1)
                freeze: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_en    = 1'b0;
                end
                ex_branch_taken: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                load_use: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    hazard     = 1'b1;
                end
                (id_PCSrc != PCSRC_SEQ): begin
                    ifid_flush = 1'b1;
                end
                default: begin
                    pc_write = 1'b1;
                end
            endcase
        end
    end

    assign stall_inc = freeze || (load_use && !ex_branch_taken);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ifid_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with small counters and a short watchdog.
// Each check goes through chk(); one summary line at the end.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_dest;
    logic [1:0]    id_PCSrc;
    logic          ex_MemRead, ex_branch_taken, mem_req, mem_ready;
    logic          pc_write, ifid_write, ifid_flush, hazard;
    logic          pipe_en, idex_flush, mem_timeout;
    logic [CW-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_PCSrc        (id_PCSrc),
        .ex_MemRead      (ex_MemRead),
        .ex_dest         (ex_dest),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .hazard          (hazard),
        .pipe_en         (pipe_en),
        .idex_flush      (idex_flush),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_PCSrc        = 2'd0;
        ex_MemRead      = 1'b0;
        ex_dest         = 5'd0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".pc_write"}, pc_write, 1);
        chk({tag, ".ifid_write"}, ifid_write, 1);
        chk({tag, ".pipe_en"}, pipe_en, 1);
        chk({tag, ".ifid_flush"}, ifid_flush, 0);
        chk({tag, ".idex_flush"}, idex_flush, 0);
        chk({tag, ".hazard"}, hazard, 0);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #3;
        chk_idle("rst");
        chk("rst.stall", stall_count, 0);
        chk("rst.flush", flush_count, 0);
        chk("rst.tmo", mem_timeout, 0);
        tick();
        reset = 1'b1;
        tick();

        // load-use on rs
        ex_MemRead = 1'b1; ex_dest = 5'd8; id_rs = 5'd8;
        #1;
        chk("lu.hazard", hazard, 1);
        chk("lu.pc_write", pc_write, 0);
        chk("lu.ifid_write", ifid_write, 0);
        chk("lu.pipe_en", pipe_en, 1);
        chk("lu.idex_flush", idex_flush, 0);
        tick();
        ex_MemRead = 1'b0;
        #1;
        chk_idle("lu_after");
        chk("lu.stall", stall_count, 1);

        // register 0 never interlocks
        ex_MemRead = 1'b1; ex_dest = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        chk("r0.hazard", hazard, 0);
        chk("r0.pc_write", pc_write, 1);
        tick();
        chk("r0.stall", stall_count, 1);

        // load-use on rt
        ex_dest = 5'd9; id_rt = 5'd9; id_rs = 5'd3;
        #1;
        chk("lurt.hazard", hazard, 1);
        tick();
        chk("lurt.stall", stall_count, 2);

        // taken branch beats load-use
        ex_dest = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1;
        id_PCSrc = 2'd1;
        #1;
        chk("br.ifid_flush", ifid_flush, 1);
        chk("br.idex_flush", idex_flush, 1);
        chk("br.hazard", hazard, 0);
        chk("br.pc_write", pc_write, 1);
        tick();
        chk("br.flush", flush_count, 1);
        chk("br.stall", stall_count, 2);

        // jump in ID
        idle();
        id_PCSrc = 2'd2;
        #1;
        chk("j.ifid_flush", ifid_flush, 1);
        chk("j.idex_flush", idex_flush, 0);
        chk("j.pc_write", pc_write, 1);
        tick();
        id_PCSrc = 2'd0;
        #1;
        chk("j.after", ifid_flush, 0);
        chk("j.flush", flush_count, 2);

        // single-cycle access: no freeze
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        chk("sc.pipe_en", pipe_en, 1);
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("sc.after", pipe_en, 1);
        chk("sc.stall", stall_count, 2);

        // three-cycle memory wait; freeze masks a taken branch
        mem_req = 1'b1;
        #1;
        chk("mw1.pipe_en", pipe_en, 0);
        tick();
        ex_branch_taken = 1'b1;
        #1;
        chk("mw2.pipe_en", pipe_en, 0);
        chk("mw2.ifid_flush", ifid_flush, 0);
        chk("mw2.pc_write", pc_write, 0);
        tick();
        ex_branch_taken = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("mw3.pipe_en", pipe_en, 0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("mw4.pipe_en", pipe_en, 1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("mw.back_run", pipe_en, 1);
        chk("mw.stall", stall_count, 5);
        chk("mw.flush", flush_count, 2);

        // watchdog: 5 frozen cycles then ERROR
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("wd.tmo_pre", mem_timeout, 0);
        tick();
        chk("wd.tmo", mem_timeout, 1);
        chk("wd.stall", stall_count, 10);
        mem_req = 1'b0; mem_ready = 1'b1;
        id_PCSrc = 2'd3;
        #1;
        chk("wd.pipe_en", pipe_en, 0);
        chk("wd.ifid_flush", ifid_flush, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("wd.hold", pipe_en, 0);
        chk("wd.tmo_hold", mem_timeout, 1);
        chk("wd.sat", stall_count, 15);
        chk("wd.flush", flush_count, 2);

        // async reset out of ERROR
        idle();
        #2;
        reset = 1'b0;
        #1;
        chk("rst2.tmo", mem_timeout, 0);
        chk("rst2.stall", stall_count, 0);
        chk("rst2.flush", flush_count, 0);
        chk_idle("rst2");
        tick();
        reset = 1'b1;
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        chk("rst2.run", pipe_en, 1);
        tick();
        chk("rst2.stall_after", stall_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their enables and flushes. It drives the PC write enable and the `hazard` bubble input of the ID stage. It handles load-use interlocks, control-transfer flushes and a data-memory wait handshake with a watchdog. It also keeps saturating stall and flush counters for performance measurement.

## Interface
- `CNT_W`, 16: width of the performance counters.
- `MEM_TIMEOUT`, 64: maximum consecutive memory-wait cycles before the watchdog trips. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_rs`  in  5  rs field of the instruction in IF/ID.
- `id_rt`  in  5  rt-or-0 source of the instruction in IF/ID; 0 when the instruction is an immediate form.
- `id_PCSrc`  in  2  ID control transfer: 0 sequential, 1 branch, 2 jump, 3 jump-register.
- `ex_MemRead`  in  1  ID/EX holds a load.
- `ex_dest`  in  5  destination register (rd-or-rt) held in ID/EX.
- `ex_branch_taken`  in  1  branch in EX resolved taken.
- `mem_req`  in  1  MEM stage is accessing data memory this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC load enable.
- `ifid_write`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  IF/ID loads a NOP.
- `hazard`  out  1  ID stage zeroes its control outputs (bubble).
- `pipe_en`  out  1  load enable for ID/EX, EX/MEM and MEM/WB.
- `idex_flush`  out  1  ID/EX loads a bubble.
- `mem_timeout`  out  1  sticky watchdog error.
- `stall_count`  out  CNT_W  saturating count of stall cycles.
- `flush_count`  out  CNT_W  saturating count of flush cycles.

## Operation
- Internal terms, all combinational:
  - `load_use = ex_MemRead & ex_dest≠0 & (ex_dest==id_rs | ex_dest==id_rt)`.
  - `freeze = (state==MEM_WAIT & ~mem_ready) | (state==RUN & mem_req & ~mem_ready) | state==ERROR`.
- Register 0 never creates a hazard.
- Priority, highest first: freeze, then EX-branch flush, then load-use, then ID jump/branch flush.
- Freeze:
  - `pc_write=ifid_write=pipe_en=0`.
  - All flushes are 0 and `hazard=0`.
  - Frozen registers hold their contents, so a taken branch in EX re-presents itself after release.
- `ex_branch_taken` with no freeze:
  - `ifid_flush=1`, `idex_flush=1`, `pc_write=1`.
  - `hazard=0`. A pending load-use is discarded.
- `load_use` with no freeze and no taken branch:
  - `pc_write=0`, `ifid_write=0`, `hazard=1`, `pipe_en=1`.
  - Exactly one bubble enters ID/EX, because the load then leaves EX.
- `id_PCSrc≠0` with none of the above: `ifid_flush=1`, which squashes the delay-slot fetch.
- Otherwise: `pc_write=ifid_write=pipe_en=1`, with all flushes and `hazard` at 0.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN → MEM_WAIT when `mem_req & ~mem_ready`.
  - MEM_WAIT → RUN when `mem_ready`.
  - MEM_WAIT → ERROR when the wait counter reaches `MEM_TIMEOUT-1` while `~mem_ready`.
  - ERROR is absorbing until reset.
- Wait counter:
  - Cleared on entry to MEM_WAIT.
  - Increments each MEM_WAIT cycle with `~mem_ready`.
  - Width is `$clog2(MEM_TIMEOUT)`.
- `mem_timeout` is set on entry to ERROR and held until reset. It is registered.
- `stall_count` increments on every cycle with `freeze | (load_use & ~ex_branch_taken)`.
- `flush_count` increments on every cycle with `ifid_flush`.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset state:
  - FSM in RUN; wait counter, both perf counters and `mem_timeout` all 0.
  - With idle inputs: `pc_write=ifid_write=pipe_en=1`; `ifid_flush=idex_flush=hazard=0`.
- Output latency:
  - Enable, flush and `hazard` outputs are Mealy, valid in the same cycle as their inputs with zero latency.
  - `mem_timeout`, `stall_count` and `flush_count` are registered, one cycle after the causing condition.
- `mem_req & mem_ready` in the same RUN cycle is a single-cycle access: no freeze and no state change.
- Reset asserted mid-wait or in ERROR: everything returns to the reset state asynchronously. Outputs show the idle values while `reset=0`.
- `mem_req` deasserting while in MEM_WAIT is a protocol violation. The controller stays frozen until `mem_ready` or the timeout.

## Structure
- Shared package `pipe_pkg`:
  - state enum {RUN, MEM_WAIT, ERROR}.
  - PCSrc constants `PCSRC_SEQ=0`, `PCSRC_BR=1`, `PCSRC_J=2`, `PCSRC_JR=3`.
  - `REG_ZERO=5'd0`.
- One sub-module, `sat_counter` (parameter W; ports clk, reset, inc, count), instantiated twice for the perf counters.

## Test plan
- Load-use: `ex_MemRead=1`, `ex_dest=8`, `id_rs=8` → one cycle with `hazard=1`, `pc_write=0`, `ifid_write=0`; next cycle, with `ex_MemRead=0`, all enables are 1; `stall_count` goes 0→1.
- No hazard on register 0: `ex_MemRead=1`, `ex_dest=0`, `id_rt=0` → `hazard=0`, `pc_write=1`.
- Taken branch plus simultaneous load-use: `ex_branch_taken=1` with load_use true → `ifid_flush=idex_flush=1`, `hazard=0`; `flush_count` +1, `stall_count` unchanged.
- Jump in ID: `id_PCSrc=2` → `ifid_flush=1` for one cycle, `idex_flush=0`.
- Memory wait: `mem_req=1`, `mem_ready=0` for 3 cycles, then `mem_ready=1` → `pipe_en=0` for 3 cycles and 1 on the 4th; state returns to RUN; `stall_count=3`.
- Watchdog and reset: `MEM_TIMEOUT=4`, `mem_ready` held 0 → ERROR, `mem_timeout=1`, freeze held indefinitely; asserting `reset=0` mid-ERROR clears everything.
